im_access_arbiter: RTL and testbench

//  Shares the single-port instruction memory between two requesters: the CPU

---
 rtl/im_access_arbiter.sv | 71 +++++++
 tb/tb_im_access_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/im_access_arbiter.sv
// im_access_arbiter: shares single-port instruction memory between fetch and loader
// Loader has priority; a saturating starve counter forces a fetch grant after STARVE_LIMIT loader wins.
module im_access_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_ack,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_ack,
   output logic [DW-1:0] l_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam int CW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata, r_rdata;
   logic r_we, r_owner;
   logic w_any, w_fwin;
   assign w_any  = f_req | l_req;
   // with STARVE_LIMIT = 0 the counter never reaches a forcing value
   assign w_fwin = f_req & (~l_req | ((STARVE_LIMIT != 0) && (r_cnt == LIM)));
   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   always_comb
      w_next = r_state == IDLE ? (w_any ? ACCESS : IDLE) : r_state == ACCESS ? RESP : IDLE;
   always_comb begin
      mem_we = (r_state == ACCESS) & r_we;
      f_ack  = (r_state == RESP) & ~r_owner;
      l_ack  = (r_state == RESP) & r_owner;
      busy   = r_state != IDLE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_we    <= 1'b0;
         r_owner <= 1'b0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_owner <= ~w_fwin;
            r_addr  <= w_fwin ? f_addr : l_addr;
            r_we    <= ~w_fwin & l_we;
            r_wdata <= w_fwin ? '0 : l_wdata;
            r_cnt   <= (f_req & l_req & ~w_fwin) ? (r_cnt == LIM ? r_cnt : r_cnt + 1'b1) : '0;
         end
         if (r_state == ACCESS) r_rdata <= r_we ? '0 : mem_rdata;
      end
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign f_rdata   = r_rdata;
   assign l_rdata   = r_rdata;
endmodule

// File: tb/tb_im_access_arbiter.sv
// tb_im_access_arbiter: directed tests for the instruction-memory arbiter
// dut uses STARVE_LIMIT=2 with a modelled memory; dut_s uses STARVE_LIMIT=0.
module tb_im_access_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   logic f_req, l_req, l_we, f_ack, l_ack, mem_we, busy;
   logic [7:0] f_addr, l_addr, mem_addr;
   logic [31:0] l_wdata, f_rdata, l_rdata, mem_wdata, mem_rdata;
   logic f_req_s, l_req_s, f_ack_s, l_ack_s, mem_we_s, busy_s;
   logic [7:0] mem_addr_s;
   logic [31:0] f_rdata_s, l_rdata_s, mem_wdata_s, mem_rdata_s;
   logic [31:0] mem [256];
   int errors = 0;
   int checks = 0;
   im_access_arbiter #(.AW(8), .DW(32), .STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_ack(l_ack), .l_rdata(l_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );
   im_access_arbiter #(.AW(8), .DW(32), .STARVE_LIMIT(0)) dut_s (
      .clk(clk), .reset(reset),
      .f_req(f_req_s), .f_addr(8'h07), .f_ack(f_ack_s), .f_rdata(f_rdata_s),
      .l_req(l_req_s), .l_we(1'b0), .l_addr(8'h09), .l_wdata(32'h0),
      .l_ack(l_ack_s), .l_rdata(l_rdata_s),
      .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdata(mem_wdata_s),
      .mem_rdata(mem_rdata_s), .busy(busy_s)
   );
   // word 5 is a preloaded ROM word; everything else is written RAM
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata   = (mem_addr == 8'h05) ? 32'h24020001 : mem[mem_addr];
   assign mem_rdata_s = {24'h0, mem_addr_s};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      f_req = 0; l_req = 0; l_we = 0; f_addr = 0; l_addr = 0; l_wdata = 0;
      f_req_s = 0; l_req_s = 0;
      step;
      step;
      checks++; if (f_ack !== 1'b0) begin errors++; $display("FAIL reset_f_ack: got %b want 0", f_ack); end
      checks++; if (l_ack !== 1'b0) begin errors++; $display("FAIL reset_l_ack: got %b want 0", l_ack); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      step;
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
      checks++; if (f_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", f_rdata); end
   endtask

   task automatic test_fetch;
      f_addr = 8'h05; f_req = 1'b1;
      step;
      checks++; if (mem_addr !== 8'h05) begin errors++; $display("FAIL fetch_addr: got %h want 05", mem_addr); end
      checks++; if ({busy, f_ack, mem_we} !== 3'b100) begin errors++; $display("FAIL fetch_access: got %b want 100", {busy, f_ack, mem_we}); end
      step;
      checks++; if ({f_ack, l_ack} !== 2'b10) begin errors++; $display("FAIL fetch_ack: got %b want 10", {f_ack, l_ack}); end
      checks++; if (f_rdata !== 32'h24020001) begin errors++; $display("FAIL fetch_data: got %h want 24020001", f_rdata); end
      f_req = 1'b0;
      step;
      checks++; if ({busy, f_ack} !== 2'b00) begin errors++; $display("FAIL fetch_idle: got %b want 00", {busy, f_ack}); end
   endtask

   task automatic test_write;
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h10; l_wdata = 32'hDEADBEEF;
      step;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b want 1", mem_we); end
      checks++; if ({mem_addr, mem_wdata} !== {8'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL write_bus: got %h %h want 10 deadbeef", mem_addr, mem_wdata); end
      step;
      checks++; if ({mem_we, l_ack, f_ack} !== 3'b010) begin errors++; $display("FAIL write_ack: got %b want 010", {mem_we, l_ack, f_ack}); end
      l_req = 1'b0; l_we = 1'b0;
      step;
      f_req = 1'b1; f_addr = 8'h10;
      step;
      step;
      checks++; if (f_ack !== 1'b1) begin errors++; $display("FAIL readback_ack: got %b want 1", f_ack); end
      checks++; if (f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_data: got %h want deadbeef", f_rdata); end
      f_req = 1'b0;
      step;
   endtask

   task automatic test_back_to_back;
      logic [1:0] want;
      f_req = 1'b1; f_addr = 8'h05; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h03;
      for (int k = 1; k <= 17; k++) begin
         step;
         want = (k % 3 != 2) ? 2'b00 : ((((k - 2) / 3) % 3 == 2) ? 2'b10 : 2'b01);
         checks++;
         if ({f_ack, l_ack} !== want) begin
            errors++;
            $display("FAIL starve2_cycle%0d: got f/l ack %b want %b", k, {f_ack, l_ack}, want);
         end
      end
      f_req = 1'b0; l_req = 1'b0;
      step;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve2_idle: got %b want 0", busy); end
   endtask

   task automatic test_strict_priority;
      int nl, nf, at;
      nl = 0; nf = 0; at = 0;
      f_req_s = 1'b1; l_req_s = 1'b1;
      for (int k = 1; k <= 59; k++) begin
         step;
         nl += int'(l_ack_s);
         nf += int'(f_ack_s);
      end
      checks++; if (nf !== 0) begin errors++; $display("FAIL strict_no_fetch: got %0d f_acks want 0", nf); end
      checks++; if (nl !== 20) begin errors++; $display("FAIL strict_loader: got %0d l_acks want 20", nl); end
      l_req_s = 1'b0;
      for (int k = 1; k <= 3 && at == 0; k++) begin
         step;
         if (f_ack_s) at = k;
      end
      checks++; if (at !== 3) begin errors++; $display("FAIL strict_release: got f_ack at cycle %0d want 3", at); end
      f_req_s = 1'b0;
      step;
   endtask

   task automatic test_reset_mid;
      f_req = 1'b1; f_addr = 8'h05;
      step;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_access: got %b want 1", busy); end
      reset = 1'b1; f_req = 1'b0;
      step;
      checks++; if ({busy, f_ack} !== 2'b00) begin errors++; $display("FAIL midrst_abort: got %b want 00", {busy, f_ack}); end
      reset = 1'b0;
      step;
      checks++; if ({busy, f_ack} !== 2'b00) begin errors++; $display("FAIL midrst_noack: got %b want 00", {busy, f_ack}); end
      f_req = 1'b1;
      step;
      step;
      checks++; if ({f_ack, f_rdata} !== {1'b1, 32'h24020001}) begin errors++; $display("FAIL midrst_refetch: got %b %h want 1 24020001", f_ack, f_rdata); end
      f_req = 1'b0;
      step;
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_write;
      test_back_to_back;
      test_strict_priority;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
